// File: rtl/ring_meas_pkg.sv
// rtl/ring_meas_pkg.sv - shared types and default widths for the ring oscillator frequency counter
package ring_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } meas_state_t;

  localparam int CNT_W_DEF  = 16;
  localparam int GATE_W_DEF = 16;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with rising-edge detect for an asynchronous pin
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ring_freq_counter.sv
// rtl/ring_freq_counter.sv - counts ring oscillator rising edges over a programmable clk-cycle window
module ring_freq_counter
  import ring_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int GATE_W      = GATE_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              osc_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] ACC_MAX = {CNT_W{1'b1}};

  meas_state_t       state, state_nxt;
  logic [GATE_W-1:0] gate_cnt, gate_cnt_nxt;
  logic [CNT_W-1:0]  acc, acc_nxt;
  logic              ovf, ovf_nxt;
  logic              osc_rise;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (osc_in),
    .sync_out (),
    .rise     (osc_rise)
  );

  always_comb begin
    state_nxt    = state;
    gate_cnt_nxt = gate_cnt;
    acc_nxt      = acc;
    ovf_nxt      = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          gate_cnt_nxt = gate_len;
          state_nxt    = ARM;
        end
      end
      ARM: begin
        acc_nxt   = '0;
        ovf_nxt   = 1'b0;
        state_nxt = (gate_cnt == '0) ? DONE : MEASURE;
      end
      MEASURE: begin
        // Saturate rather than wrap so a too-fast oscillator reads as full scale.
        if (osc_rise) begin
          if (acc == ACC_MAX) ovf_nxt = 1'b1;
          else                acc_nxt = acc + CNT_W'(1);
        end
        gate_cnt_nxt = gate_cnt - GATE_W'(1);
        if (gate_cnt == GATE_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gate_cnt <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_cnt_nxt;
      acc      <= acc_nxt;
      ovf      <= ovf_nxt;
      // Capture on entry to DONE so the final MEASURE cycle's edge is included.
      if (state_nxt == DONE && state != DONE) begin
        count    <= acc_nxt;
        overflow <= ovf_nxt;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
